gpr_dump_reader: RTL and testbench

Sequential read-side engine for the 32x32 general-purpose register file. On a start pulse it walks an index range over one dedicated RF read port and streams each register's index and value out on a valid/ready interface. It finishes with a done pulse and an XOR checksum. It sits beside the pipeline's decode-stage read ports and serves debug and testbench register dumps while the write-back stage keeps writing.

---
 rtl/gpr_dump_reader_pkg.sv | 21 ++
 rtl/gpr_dump_outreg.sv | 51 +++++
 rtl/gpr_dump_reader.sv | 132 +++++++++++++
 tb/tb_gpr_dump_reader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: geometry defaults
// (also used by the register file itself) and the FSM state encoding.
package gpr_dump_reader_pkg;

    localparam int DEF_NREG   = 32;
    localparam int DEF_IDX_W  = 5;
    localparam int DEF_DATA_W = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        READ  = ST_READ,
        DRAIN = ST_DRAIN,
        FIN   = ST_FIN
    } dump_state_t;

endpackage

// File: rtl/gpr_dump_outreg.sv
// Single-entry output holding register with valid/ready handshake and a
// running XOR of every word the consumer accepts.
module gpr_dump_outreg
    import gpr_dump_reader_pkg::*;
#(
    parameter int IDX_W  = DEF_IDX_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              load,
    input  logic              flush,
    input  logic              acc_clr,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] acc,
    output logic              accept
);

    assign accept = out_valid && out_ready;

    // A flush drops the held word and suppresses that cycle's accumulation.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            acc       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            if (acc_clr) begin
                acc <= '0;
            end else if (accept) begin
                acc <= acc ^ out_data;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_idx   <= load_idx;
                out_data  <= load_data;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gpr_dump_reader.sv
// Walks a wrapping register index range over one RF read port and streams
// index/value pairs out, ending with a done pulse and an XOR checksum.
module gpr_dump_reader
    import gpr_dump_reader_pkg::*;
#(
    parameter int NREG   = DEF_NREG,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  first_idx,
    input  logic [IDX_W-1:0]  last_idx,
    input  logic              abort,
    output logic [IDX_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    dump_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [DATA_W-1:0] checksum_q;
    logic [DATA_W-1:0] acc;
    logic              accept;
    logic              load;
    logic              flush;
    logic              acc_clr;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            last_q     <= '0;
            checksum_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            if (state_q == FIN) begin
                checksum_q <= acc;
            end
        end
    end

    // Abort outranks capture/accept; the index wraps explicitly at NREG.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        load    = 1'b0;
        flush   = 1'b0;
        acc_clr = 1'b0;
        rd_addr = '0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = first_idx;
                    last_d  = last_idx;
                    acc_clr = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                rd_addr = idx_q;
                busy    = 1'b1;
                if (abort) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (!out_valid || out_ready) begin
                    load = 1'b1;
                    if (idx_q == last_q) begin
                        state_d = DRAIN;
                    end else if (idx_q == IDX_W'(NREG - 1)) begin
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                rd_addr = idx_q;
                busy    = 1'b1;
                if (abort) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (accept) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // During the done cycle the accumulator already holds the final value.
    assign checksum = (state_q == FIN) ? acc : checksum_q;

    gpr_dump_outreg #(
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) u_outreg (
        .clk       (clk),
        .clr_n     (clr_n),
        .load      (load),
        .flush     (flush),
        .acc_clr   (acc_clr),
        .load_idx  (idx_q),
        .load_data (rd_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .acc       (acc),
        .accept    (accept)
    );

endmodule

// File: tb/tb_gpr_dump_reader.sv
// Directed bench for gpr_dump_reader with a behavioural 32x32 register file.
module tb_gpr_dump_reader;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic [4:0]  first_idx;
    logic [4:0]  last_idx;
    logic        abort;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    logic [31:0] rf [32];
    int vectors;
    int miscompares;
    int accepts;

    int  exp2 [4] = '{30, 31, 0, 1};
    bit  pat3 [10] = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 1};

    assign rd_data = rf[rd_addr];

    gpr_dump_reader dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .first_idx (first_idx),
        .last_idx  (last_idx),
        .abort     (abort),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle start; returns one step after the sampling edge.
    task automatic applyStimulus(input logic [4:0] f, input logic [4:0] l);
        start     = 1'b1;
        first_idx = f;
        last_idx  = l;
        tick();
        start = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        accepts     = 0;
        clr_n       = 1'b0;
        start       = 1'b0;
        first_idx   = '0;
        last_idx    = '0;
        abort       = 1'b0;
        out_ready   = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;

        #2;
        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_checksum", checksum, 32'd0);
        checkOutput("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
        tick();
        clr_n = 1'b1;
        tick();

        $display("[TB] full dump 0..31");
        applyStimulus(5'd0, 5'd31);
        checkOutput("t1_first_valid_early", {31'd0, out_valid}, 32'd0);
        checkOutput("t1_busy_k0", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (k <= 32) begin
                checkOutput("t1_valid", {31'd0, out_valid}, 32'd1);
                checkOutput("t1_idx", {27'd0, out_idx}, k - 1);
                checkOutput("t1_data", out_data, 32'h1000_0000 + k - 1);
            end
            if (k == 32) checkOutput("t1_done_early", {31'd0, done}, 32'd0);
            if (k == 33) begin
                checkOutput("t1_done", {31'd0, done}, 32'd1);
                checkOutput("t1_busy_end", {31'd0, busy}, 32'd0);
                checkOutput("t1_checksum", checksum, 32'h0000_0000);
            end
        end
        tick();
        checkOutput("t1_done_one_cycle", {31'd0, done}, 32'd0);

        $display("[TB] wrapping dump 30..1");
        applyStimulus(5'd30, 5'd1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k <= 4) checkOutput("t2_idx", {27'd0, out_idx}, exp2[k-1]);
            if (k == 4) checkOutput("t2_busy", {31'd0, busy}, 32'd1);
            if (k == 5) begin
                checkOutput("t2_done", {31'd0, done}, 32'd1);
                checkOutput("t2_busy_drop", {31'd0, busy}, 32'd0);
                checkOutput("t2_checksum", checksum, 32'h0000_0000);
            end
        end
        tick();

        $display("[TB] backpressured dump 5..8");
        applyStimulus(5'd5, 5'd8);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) tick();
            out_ready = pat3[k];
            if (out_valid && out_ready) accepts++;
            if (k == 1 || k == 2) begin
                checkOutput("t3_stall_idx", {27'd0, out_idx}, 32'd5);
                checkOutput("t3_stall_data", out_data, 32'h1000_0005);
                checkOutput("t3_stall_rd_addr", {27'd0, rd_addr}, 32'd6);
            end
            if (k == 4) begin
                checkOutput("t3_idx_k4", {27'd0, out_idx}, 32'd6);
                checkOutput("t3_rd_addr_k4", {27'd0, rd_addr}, 32'd7);
            end
            if (k == 7) begin
                checkOutput("t3_drain_idx", {27'd0, out_idx}, 32'd8);
                checkOutput("t3_drain_rd_addr", {27'd0, rd_addr}, 32'd8);
                checkOutput("t3_drain_busy", {31'd0, busy}, 32'd1);
            end
            if (k == 8) begin
                checkOutput("t3_drain_hold_idx", {27'd0, out_idx}, 32'd8);
                checkOutput("t3_done_early", {31'd0, done}, 32'd0);
            end
            if (k == 9) begin
                checkOutput("t3_done", {31'd0, done}, 32'd1);
                checkOutput("t3_checksum", checksum, 32'h0000_000C);
                checkOutput("t3_accepts", accepts, 32'd4);
            end
        end
        out_ready = 1'b1;
        tick();

        $display("[TB] full dump with concurrent RF writes");
        applyStimulus(5'd0, 5'd31);
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (k == 10) begin
                rf[3]  = 32'h0000_DEAD;
                rf[20] = 32'h0000_BEEF;
            end
            if (k == 4) begin
                checkOutput("t4_reg3_idx", {27'd0, out_idx}, 32'd3);
                checkOutput("t4_reg3_old", out_data, 32'h1000_0003);
            end
            if (k == 21) begin
                checkOutput("t4_reg20_idx", {27'd0, out_idx}, 32'd20);
                checkOutput("t4_reg20_new", out_data, 32'h0000_BEEF);
            end
            if (k == 33) begin
                checkOutput("t4_done", {31'd0, done}, 32'd1);
                checkOutput("t4_checksum", checksum, 32'h1000_BEFB);
            end
        end
        rf[3]  = 32'h1000_0003;
        rf[20] = 32'h1000_0014;
        tick();

        $display("[TB] abort on third accept");
        applyStimulus(5'd0, 5'd31);
        for (int k = 1; k <= 3; k++) tick();
        checkOutput("t5_pre_abort_idx", {27'd0, out_idx}, 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("t5_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t5_busy", {31'd0, busy}, 32'd0);
        checkOutput("t5_done", {31'd0, done}, 32'd0);
        checkOutput("t5_checksum_kept", checksum, 32'h1000_BEFB);
        checkOutput("t5_rd_addr", {27'd0, rd_addr}, 32'd0);
        applyStimulus(5'd2, 5'd3);
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 1) checkOutput("t5_restart_idx2", {27'd0, out_idx}, 32'd2);
            if (k == 2) checkOutput("t5_restart_idx3", {27'd0, out_idx}, 32'd3);
            if (k == 3) begin
                checkOutput("t5_restart_done", {31'd0, done}, 32'd1);
                checkOutput("t5_restart_checksum", checksum, 32'h0000_0001);
            end
        end
        tick();

        $display("[TB] start reissued mid-dump, then async reset");
        applyStimulus(5'd0, 5'd31);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 5) begin
                start     = 1'b1;
                first_idx = 5'd20;
                last_idx  = 5'd21;
            end
            if (k == 6) begin
                start = 1'b0;
                checkOutput("t6_ignored_idx", {27'd0, out_idx}, 32'd5);
                checkOutput("t6_ignored_busy", {31'd0, busy}, 32'd1);
            end
            if (k == 7) begin
                checkOutput("t6_continue_idx", {27'd0, out_idx}, 32'd6);
                checkOutput("t6_continue_data", out_data, 32'h1000_0006);
            end
        end
        #2;
        clr_n = 1'b0;
        #1;
        checkOutput("t6_arst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t6_arst_idx", {27'd0, out_idx}, 32'd0);
        checkOutput("t6_arst_data", out_data, 32'd0);
        checkOutput("t6_arst_busy", {31'd0, busy}, 32'd0);
        checkOutput("t6_arst_rd_addr", {27'd0, rd_addr}, 32'd0);
        checkOutput("t6_arst_checksum", checksum, 32'd0);
        #5;
        clr_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
